// File: rtl/mpc_sample_scheduler.sv
// mpc_sample_scheduler: periodic launcher, x0 server, u0 saturator and watchdog for an ap_ctrl_hs mpc core
module mpc_sample_scheduler #(
    parameter int                  W           = 32,
    parameter int                  PERIOD_CYC  = 10000,
    parameter int                  TIMEOUT_CYC = 9000,
    parameter int                  RST_CYC     = 2,
    parameter logic signed [W-1:0] U_MIN       = -(2**(W-2)),
    parameter logic signed [W-1:0] U_MAX       = 2**(W-2)-1,
    parameter logic signed [W-1:0] U_SAFE      = '0,
    parameter int                  CNT_W       = 16
) (
    input  logic             clk_1,
    input  logic             ap_rst,
    input  logic             en,
    input  logic             clr_flags,
    input  logic [W-1:0]     x_meas_0,
    input  logic [W-1:0]     x_meas_1,
    input  logic [W-1:0]     r_meas,
    output logic [W-1:0]     mpc_r,
    input  logic             x0_address0,
    input  logic             x0_address1,
    input  logic             x0_ce0,
    input  logic             x0_ce1,
    output logic [W-1:0]     x0_q0,
    output logic [W-1:0]     x0_q1,
    output logic             mpc_ap_start,
    input  logic             mpc_ap_done,
    input  logic             mpc_ap_ready,
    input  logic             mpc_ap_idle,
    input  logic [W-1:0]     mpc_u0,
    input  logic             mpc_u0_ap_vld,
    output logic             mpc_rst,
    output logic [W-1:0]     u_out,
    output logic             u_valid,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic             timeout_flt
);
    localparam int TW = $clog2(PERIOD_CYC);
    localparam int OW = $clog2(TIMEOUT_CYC + 1);
    localparam int AW = $clog2(RST_CYC + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;

    logic [1:0]    r_state;
    logic [TW-1:0] r_tcnt;
    logic [OW-1:0] r_tocnt;
    logic [AW-1:0] r_acnt;
    logic [W-1:0]  r_xbuf [2];
    logic          w_tick;
    logic          w_fire;
    logic          w_launch;
    logic          w_ovr;
    logic          w_abort;
    logic [W-1:0]  w_u_sat;
    logic          w_unused;

    assign w_unused = mpc_ap_idle;
    assign w_tick   = r_tcnt == TW'(PERIOD_CYC - 1);
    assign w_fire   = w_tick & en;
    assign w_launch = w_fire & ((r_state == S_IDLE) | ((r_state == S_RUN) & mpc_ap_done));
    assign w_ovr    = w_fire & (((r_state == S_RUN) & ~mpc_ap_done) | (r_state == S_ABORT));
    assign w_abort  = (r_state == S_RUN) & ~mpc_ap_done & (r_tocnt == OW'(TIMEOUT_CYC - 1));
    assign w_u_sat  = $signed(mpc_u0) > U_MAX ? U_MAX : $signed(mpc_u0) < U_MIN ? U_MIN : mpc_u0;
    assign busy     = r_state != S_IDLE;
    assign mpc_rst  = r_state == S_ABORT;

    // free-running sample period counter, tick on its last count
    always_ff @(posedge clk_1) begin
        if (ap_rst) r_tcnt <= '0;
        else        r_tcnt <= w_tick ? '0 : r_tcnt + 1'b1;
    end

    // sequencer: launch/snapshot, start handshake, u0 capture, watchdog abort
    always_ff @(posedge clk_1) begin
        if (ap_rst) begin
            r_state      <= S_IDLE;
            r_tocnt      <= '0;
            r_acnt       <= '0;
            r_xbuf[0]    <= '0;
            r_xbuf[1]    <= '0;
            mpc_r        <= '0;
            mpc_ap_start <= 1'b0;
            u_out        <= '0;
            u_valid      <= 1'b0;
        end else begin
            u_valid <= 1'b0;
            r_tocnt <= r_tocnt + 1'b1;
            if ((r_state == S_RUN) & mpc_u0_ap_vld) begin
                u_out   <= w_u_sat;
                u_valid <= 1'b1;
            end
            if ((r_state == S_RUN) & mpc_ap_ready) mpc_ap_start <= 1'b0;
            if ((r_state == S_RUN) & mpc_ap_done) r_state <= S_IDLE;
            if (r_state == S_ABORT) begin
                r_acnt <= r_acnt + 1'b1;
                if (r_acnt == AW'(RST_CYC - 1)) begin
                    r_state <= S_IDLE;
                    r_acnt  <= '0;
                end
            end
            if (w_abort) begin
                r_state      <= S_ABORT;
                mpc_ap_start <= 1'b0;
                u_out        <= U_SAFE;
                u_valid      <= 1'b1;
            end
            if (w_launch) begin
                r_state      <= S_RUN;
                r_tocnt      <= '0;
                mpc_ap_start <= 1'b1;
                r_xbuf[0]    <= x_meas_0;
                r_xbuf[1]    <= x_meas_1;
                mpc_r        <= r_meas;
            end
        end
    end

    // sticky fault flags; a new event beats a simultaneous clear
    always_ff @(posedge clk_1) begin
        if (ap_rst) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
            timeout_flt <= 1'b0;
        end else begin
            overrun     <= w_ovr | (overrun & ~clr_flags);
            overrun_cnt <= clr_flags ? CNT_W'(w_ovr) : overrun_cnt + CNT_W'(w_ovr & ~&overrun_cnt);
            timeout_flt <= w_abort | (timeout_flt & ~clr_flags);
        end
    end

    // registered x0 read ports, value held while ce is low
    always_ff @(posedge clk_1) begin
        if (ap_rst) begin
            x0_q0 <= '0;
            x0_q1 <= '0;
        end else begin
            if (x0_ce0) x0_q0 <= r_xbuf[x0_address0];
            if (x0_ce1) x0_q1 <= r_xbuf[x0_address1];
        end
    end
endmodule

// File: tb/tb_mpc_sample_scheduler.sv
// tb_mpc_sample_scheduler: directed bench; u_a has the nominal watchdog, u_b a long one so solves can span a tick
module tb_mpc_sample_scheduler;
    logic clk_1 = 1'b0;
    logic ap_rst = 1'b1;
    logic en = 1'b1;
    logic clr_flags = 1'b0;
    logic [31:0] x_meas_0 = '0;
    logic [31:0] x_meas_1 = '0;
    logic [31:0] r_meas = '0;
    logic x0_address0 = 1'b0;
    logic x0_address1 = 1'b0;
    logic x0_ce0 = 1'b0;
    logic x0_ce1 = 1'b0;
    logic idle_in = 1'b0;

    logic a_ready = 1'b0, a_done = 1'b0, a_vld = 1'b0;
    logic signed [31:0] a_u0 = '0;
    logic a_start, a_mpc_rst, a_u_valid, a_busy, a_overrun, a_tflt;
    logic signed [31:0] a_u_out;
    logic [31:0] a_mpc_r, a_q0, a_q1;
    logic [15:0] a_cnt;

    logic b_ready = 1'b0, b_done = 1'b0, b_vld = 1'b0;
    logic signed [31:0] b_u0 = '0;
    logic b_start, b_mpc_rst, b_u_valid, b_busy, b_overrun, b_tflt;
    logic signed [31:0] b_u_out;
    logic [31:0] b_mpc_r, b_q0, b_q1;
    logic [15:0] b_cnt;

    int vec = 0;
    int errs = 0;
    int n = 0;
    int lat = 6;
    logic hang = 1'b0;
    logic signed [31:0] u0v = 42;
    int k = -1;

    mpc_sample_scheduler #(.W(32), .PERIOD_CYC(20), .TIMEOUT_CYC(15), .RST_CYC(2), .U_MIN(-100), .U_MAX(100), .U_SAFE(0), .CNT_W(16)) u_a (
        .clk_1(clk_1), .ap_rst(ap_rst), .en(en), .clr_flags(clr_flags),
        .x_meas_0(x_meas_0), .x_meas_1(x_meas_1), .r_meas(r_meas), .mpc_r(a_mpc_r),
        .x0_address0(x0_address0), .x0_address1(x0_address1), .x0_ce0(x0_ce0), .x0_ce1(x0_ce1),
        .x0_q0(a_q0), .x0_q1(a_q1), .mpc_ap_start(a_start), .mpc_ap_done(a_done),
        .mpc_ap_ready(a_ready), .mpc_ap_idle(idle_in), .mpc_u0(a_u0), .mpc_u0_ap_vld(a_vld),
        .mpc_rst(a_mpc_rst), .u_out(a_u_out), .u_valid(a_u_valid), .busy(a_busy),
        .overrun(a_overrun), .overrun_cnt(a_cnt), .timeout_flt(a_tflt));

    mpc_sample_scheduler #(.W(32), .PERIOD_CYC(20), .TIMEOUT_CYC(50), .RST_CYC(2), .U_MIN(-100), .U_MAX(100), .U_SAFE(0), .CNT_W(16)) u_b (
        .clk_1(clk_1), .ap_rst(ap_rst), .en(en), .clr_flags(clr_flags),
        .x_meas_0(x_meas_0), .x_meas_1(x_meas_1), .r_meas(r_meas), .mpc_r(b_mpc_r),
        .x0_address0(x0_address0), .x0_address1(x0_address1), .x0_ce0(x0_ce0), .x0_ce1(x0_ce1),
        .x0_q0(b_q0), .x0_q1(b_q1), .mpc_ap_start(b_start), .mpc_ap_done(b_done),
        .mpc_ap_ready(b_ready), .mpc_ap_idle(idle_in), .mpc_u0(b_u0), .mpc_u0_ap_vld(b_vld),
        .mpc_rst(b_mpc_rst), .u_out(b_u_out), .u_valid(b_u_valid), .busy(b_busy),
        .overrun(b_overrun), .overrun_cnt(b_cnt), .timeout_flt(b_tflt));

    always #5 clk_1 = ~clk_1;

    // edges since the last reset; equals the scheduler's period counter modulo 20
    always @(posedge clk_1) n <= ap_rst ? 0 : n + 1;

    // core model for u_a: ready on first start, done+vld lat cycles later unless hung
    always @(posedge clk_1) begin
        #1;
        a_ready = 1'b0;
        a_done = 1'b0;
        a_vld = 1'b0;
        if (ap_rst || a_mpc_rst) k = -1;
        else if (k < 0) begin
            if (a_start) begin
                k = 0;
                a_ready = 1'b1;
            end
        end else begin
            k++;
            if (!hang && k == lat) begin
                a_done = 1'b1;
                a_vld = 1'b1;
                a_u0 = u0v;
                k = -1;
            end
        end
    end

    task automatic go(input int m);
        int g = 0;
        while (n != m && g < 1000) begin
            @(posedge clk_1);
            #2;
            g++;
        end
        vec++; if (n != m) begin errs++; $display("FAIL go_bound n=%0d want=%0d", n, m); end
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        repeat (2) @(posedge clk_1);
        #2 ap_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if ({a_busy, a_start, a_mpc_rst, a_u_valid, a_overrun, a_tflt} !== 6'b0) begin errs++; $display("FAIL rst_a_bits got=%b want=000000", {a_busy, a_start, a_mpc_rst, a_u_valid, a_overrun, a_tflt}); end
        vec++; if ({a_u_out, a_mpc_r, a_q0, a_q1, a_cnt} !== '0) begin errs++; $display("FAIL rst_a_words got=%h want=0", {a_u_out, a_mpc_r, a_q0, a_q1, a_cnt}); end
        vec++; if ({b_busy, b_start, b_mpc_rst, b_u_valid, b_overrun, b_tflt} !== 6'b0) begin errs++; $display("FAIL rst_b_bits got=%b want=000000", {b_busy, b_start, b_mpc_rst, b_u_valid, b_overrun, b_tflt}); end
        go(19);
        vec++; if ({a_busy, a_start} !== 2'b00) begin errs++; $display("FAIL rst_prelaunch got=%b want=00", {a_busy, a_start}); end
    endtask

    task automatic test_nominal();
        lat = 6; u0v = 42;
        go(20);
        vec++; if ({a_start, a_busy} !== 2'b11) begin errs++; $display("FAIL nom_launch got=%b want=11", {a_start, a_busy}); end
        go(21);
        vec++; if ({a_start, a_busy} !== 2'b01) begin errs++; $display("FAIL nom_ready_drop got=%b want=01", {a_start, a_busy}); end
        go(26);
        vec++; if ({a_u_valid, a_busy} !== 2'b01) begin errs++; $display("FAIL nom_pre_vld got=%b want=01", {a_u_valid, a_busy}); end
        go(27);
        vec++; if (a_u_out !== 42) begin errs++; $display("FAIL nom_u_out got=%0d want=42", a_u_out); end
        vec++; if ({a_u_valid, a_busy} !== 2'b10) begin errs++; $display("FAIL nom_vld_done got=%b want=10", {a_u_valid, a_busy}); end
        go(28);
        vec++; if (a_u_valid !== 1'b0) begin errs++; $display("FAIL nom_vld_pulse got=%b want=0", a_u_valid); end
        u0v = 500;
        go(40);
        vec++; if ({a_start, a_busy, a_overrun} !== 3'b110) begin errs++; $display("FAIL nom_relaunch got=%b want=110", {a_start, a_busy, a_overrun}); end
    endtask

    task automatic test_saturation();
        go(47);
        vec++; if (a_u_out !== 100) begin errs++; $display("FAIL sat_hi got=%0d want=100", a_u_out); end
        u0v = -7;
        go(67);
        vec++; if (a_u_out !== -7) begin errs++; $display("FAIL sat_mid got=%0d want=-7", a_u_out); end
        u0v = -500;
        go(87);
        vec++; if (a_u_out !== -100) begin errs++; $display("FAIL sat_lo got=%0d want=-100", a_u_out); end
        u0v = 100;
        go(107);
        vec++; if (a_u_out !== 100) begin errs++; $display("FAIL sat_edge_hi got=%0d want=100", a_u_out); end
        u0v = -101;
        go(127);
        vec++; if (a_u_out !== -100) begin errs++; $display("FAIL sat_edge_lo got=%0d want=-100", a_u_out); end
    endtask

    task automatic test_hang();
        hang = 1'b1;
        go(154);
        vec++; if ({a_mpc_rst, a_busy, a_tflt} !== 3'b010) begin errs++; $display("FAIL hang_pre got=%b want=010", {a_mpc_rst, a_busy, a_tflt}); end
        go(155);
        vec++; if ({a_mpc_rst, a_start, a_u_valid, a_tflt} !== 4'b1011) begin errs++; $display("FAIL hang_abort got=%b want=1011", {a_mpc_rst, a_start, a_u_valid, a_tflt}); end
        vec++; if (a_u_out !== 0) begin errs++; $display("FAIL hang_safe got=%0d want=0", a_u_out); end
        go(156);
        vec++; if ({a_mpc_rst, a_u_valid, a_busy} !== 3'b101) begin errs++; $display("FAIL hang_rst2 got=%b want=101", {a_mpc_rst, a_u_valid, a_busy}); end
        go(157);
        vec++; if ({a_mpc_rst, a_busy, a_tflt} !== 3'b001) begin errs++; $display("FAIL hang_exit got=%b want=001", {a_mpc_rst, a_busy, a_tflt}); end
        hang = 1'b0;
        go(158);
        clr_flags = 1'b1;
        go(159);
        clr_flags = 1'b0;
        vec++; if (a_tflt !== 1'b0) begin errs++; $display("FAIL hang_clr got=%b want=0", a_tflt); end
    endtask

    task automatic test_xread();
        do_reset();
        lat = 6; u0v = 42;
        x_meas_0 = 32'h11; x_meas_1 = 32'h22; r_meas = 32'h33;
        go(20);
        vec++; if (a_mpc_r !== 32'h33) begin errs++; $display("FAIL xr_mpc_r got=%h want=33", a_mpc_r); end
        x0_ce0 = 1'b1; x0_address0 = 1'b0; x0_ce1 = 1'b1; x0_address1 = 1'b1;
        go(21);
        vec++; if ({a_q0, a_q1} !== {32'h11, 32'h22}) begin errs++; $display("FAIL xr_dual got=%h/%h want=11/22", a_q0, a_q1); end
        x0_ce0 = 1'b0; x0_ce1 = 1'b0;
        x_meas_0 = 32'h55; x_meas_1 = 32'h66;
        go(25);
        vec++; if ({a_q0, a_q1, a_busy} !== {32'h11, 32'h22, 1'b1}) begin errs++; $display("FAIL xr_hold got=%h/%h busy=%b want=11/22 busy=1", a_q0, a_q1, a_busy); end
        x0_ce0 = 1'b1; x0_address0 = 1'b1; x0_ce1 = 1'b1; x0_address1 = 1'b0;
        go(26);
        vec++; if ({a_q0, a_q1} !== {32'h22, 32'h11}) begin errs++; $display("FAIL xr_swap got=%h/%h want=22/11", a_q0, a_q1); end
        x0_ce0 = 1'b0; x0_ce1 = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        x_meas_0 = 32'h11; x_meas_1 = 32'h22; r_meas = 32'h33;
        go(30);
        vec++; if ({b_start, b_busy} !== 2'b11) begin errs++; $display("FAIL ov_start_held got=%b want=11", {b_start, b_busy}); end
        go(39);
        x_meas_0 = 32'h55; x_meas_1 = 32'h66; r_meas = 32'h77;
        go(40);
        vec++; if ({b_overrun, b_cnt} !== {1'b1, 16'd1}) begin errs++; $display("FAIL ov_flag got=%b cnt=%0d want=1 cnt=1", b_overrun, b_cnt); end
        vec++; if (b_mpc_r !== 32'h33) begin errs++; $display("FAIL ov_mpc_r got=%h want=33", b_mpc_r); end
        vec++; if (a_overrun !== 1'b0) begin errs++; $display("FAIL ov_a_clean got=%b want=0", a_overrun); end
        x0_ce0 = 1'b1; x0_address0 = 1'b0; x0_ce1 = 1'b1; x0_address1 = 1'b1;
        go(41);
        vec++; if ({b_q0, b_q1} !== {32'h11, 32'h22}) begin errs++; $display("FAIL ov_xbuf_kept got=%h/%h want=11/22", b_q0, b_q1); end
        vec++; if ({a_q0, a_q1} !== {32'h55, 32'h66}) begin errs++; $display("FAIL ov_a_relatch got=%h/%h want=55/66", a_q0, a_q1); end
        x0_ce0 = 1'b0; x0_ce1 = 1'b0;
        go(59);
        r_meas = 32'h99; b_done = 1'b1; b_ready = 1'b1; b_vld = 1'b1; b_u0 = 42;
        go(60);
        b_done = 1'b0; b_ready = 1'b0; b_vld = 1'b0;
        vec++; if ({b_start, b_busy, b_u_valid, b_overrun} !== 4'b1111) begin errs++; $display("FAIL ov_coinc got=%b want=1111", {b_start, b_busy, b_u_valid, b_overrun}); end
        vec++; if ({b_mpc_r, b_cnt} !== {32'h99, 16'd1}) begin errs++; $display("FAIL ov_coinc_data got=%h cnt=%0d want=99 cnt=1", b_mpc_r, b_cnt); end
        vec++; if (b_u_out !== 42) begin errs++; $display("FAIL ov_coinc_u got=%0d want=42", b_u_out); end
        go(61);
        vec++; if ({b_start, b_u_valid} !== 2'b10) begin errs++; $display("FAIL ov_hold2 got=%b want=10", {b_start, b_u_valid}); end
        b_ready = 1'b1;
        go(62);
        b_ready = 1'b0;
        vec++; if (b_start !== 1'b0) begin errs++; $display("FAIL ov_ready_drop got=%b want=0", b_start); end
        go(79);
        clr_flags = 1'b1;
        go(80);
        clr_flags = 1'b0;
        vec++; if ({b_overrun, b_cnt} !== {1'b1, 16'd1}) begin errs++; $display("FAIL ov_clr_race got=%b cnt=%0d want=1 cnt=1", b_overrun, b_cnt); end
        go(100);
        vec++; if ({b_overrun, b_cnt} !== {1'b1, 16'd2}) begin errs++; $display("FAIL ov_cnt2 got=%b cnt=%0d want=1 cnt=2", b_overrun, b_cnt); end
        vec++; if (a_overrun !== 1'b0) begin errs++; $display("FAIL ov_a_clean2 got=%b want=0", a_overrun); end
    endtask

    task automatic test_rst_en();
        hang = 1'b1;
        go(106);
        vec++; if (a_busy !== 1'b1) begin errs++; $display("FAIL re_midrun got=%b want=1", a_busy); end
        do_reset();
        hang = 1'b0;
        en = 1'b0;
        vec++; if ({a_busy, a_start, a_mpc_rst, a_u_valid, a_overrun, a_tflt} !== 6'b0) begin errs++; $display("FAIL re_a_bits got=%b want=000000", {a_busy, a_start, a_mpc_rst, a_u_valid, a_overrun, a_tflt}); end
        vec++; if ({a_u_out, a_mpc_r, a_q0, a_q1, a_cnt} !== '0) begin errs++; $display("FAIL re_a_words got=%h want=0", {a_u_out, a_mpc_r, a_q0, a_q1, a_cnt}); end
        vec++; if ({b_busy, b_start, b_overrun, b_cnt} !== '0) begin errs++; $display("FAIL re_b_flags got=%h want=0", {b_busy, b_start, b_overrun, b_cnt}); end
        vec++; if ({b_u_out, b_mpc_r, b_q0, b_q1} !== '0) begin errs++; $display("FAIL re_b_words got=%h want=0", {b_u_out, b_mpc_r, b_q0, b_q1}); end
        go(20);
        vec++; if ({a_start, a_busy, b_start, b_busy} !== 4'b0) begin errs++; $display("FAIL re_en_off got=%b want=0000", {a_start, a_busy, b_start, b_busy}); end
        go(21);
        vec++; if ({a_busy, a_overrun} !== 2'b00) begin errs++; $display("FAIL re_en_off2 got=%b want=00", {a_busy, a_overrun}); end
        go(30);
        en = 1'b1;
        go(40);
        vec++; if ({a_start, a_busy} !== 2'b11) begin errs++; $display("FAIL re_en_on got=%b want=11", {a_start, a_busy}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_hang();
        test_xread();
        test_overrun();
        test_rst_en();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
